// File: rtl/alu_pkg.sv
// Shared ALU definitions: operator codes, RV32I opcode/funct7 constants,
// output-register state type and immediate sign-extension helpers.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NONE = 4'd15;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

  // Sign-extend a 12-bit immediate to the 32-bit datapath.
  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    logic signed [11:0] s;
    s = v;
    return 32'(s);
  endfunction

endpackage

// File: rtl/alu_op_encoder_if.sv
// Upstream issue / downstream ALU handshake bundle for alu_op_encoder.
interface alu_op_encoder_if #(
  parameter int D_WIDTH = 32,
  parameter int OP_W    = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        instr;
  logic [D_WIDTH-1:0] pc;
  logic [D_WIDTH-1:0] rs1_data;
  logic [D_WIDTH-1:0] rs2_data;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    operator;
  logic [D_WIDTH-1:0] a;
  logic [D_WIDTH-1:0] b;
  logic [4:0]         rd;
  logic               reg_write;
  logic               illegal;

  // Driver side: register-read stage plus ALU consumer.
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, out_valid, operator, a, b, rd, reg_write, illegal
  );

  // Encoder side.
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, out_valid, operator, a, b, rd, reg_write, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational RV32I decode into ALU operator, operands and writeback info.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int OP_W    = 4
) (
  input  logic [31:0]        instr,
  input  logic [D_WIDTH-1:0] pc,
  input  logic [D_WIDTH-1:0] rs1_data,
  input  logic [D_WIDTH-1:0] rs2_data,
  output logic [OP_W-1:0]    operator,
  output logic [D_WIDTH-1:0] a,
  output logic [D_WIDTH-1:0] b,
  output logic [4:0]         rd,
  output logic               reg_write,
  output logic               illegal
);

  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [6:0]                funct7;
  logic signed [D_WIDTH-1:0] imm_i;
  logic signed [D_WIDTH-1:0] imm_s;
  logic signed [D_WIDTH-1:0] imm_u;
  logic [D_WIDTH-1:0]        shamt_r;
  logic [D_WIDTH-1:0]        shamt_i;
  logic                      bad;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = sext12(instr[31:20]);
  assign imm_s   = sext12({instr[31:25], instr[11:7]});
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt_r = {{(D_WIDTH-5){1'b0}}, rs2_data[4:0]};
  assign shamt_i = {{(D_WIDTH-5){1'b0}}, instr[24:20]};
  assign rd      = instr[11:7];

  // Opcode/funct decode; a bad encoding collapses to the "none" operation.
  always_comb begin
    operator  = ALU_NONE;
    a         = '0;
    b         = '0;
    reg_write = 1'b0;
    bad       = 1'b0;
    case (opcode)
      OPC_OP: begin
        a         = rs1_data;
        b         = rs2_data;
        reg_write = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == F7_BASE)     operator = ALU_ADD;
            else if (funct7 == F7_ALT) operator = ALU_SUB;
            else                       bad = 1'b1;
          end
          3'b001: begin
            operator = ALU_SLL;
            b        = shamt_r;
            bad      = (funct7 != F7_BASE);
          end
          3'b010: begin operator = ALU_SLT;  bad = (funct7 != F7_BASE); end
          3'b011: begin operator = ALU_SLTU; bad = (funct7 != F7_BASE); end
          3'b100: begin operator = ALU_XOR;  bad = (funct7 != F7_BASE); end
          3'b101: begin
            b = shamt_r;
            if (funct7 == F7_BASE)     operator = ALU_SRL;
            else if (funct7 == F7_ALT) operator = ALU_SRA;
            else                       bad = 1'b1;
          end
          3'b110: begin operator = ALU_OR;  bad = (funct7 != F7_BASE); end
          default: begin operator = ALU_AND; bad = (funct7 != F7_BASE); end
        endcase
      end
      OPC_OPIMM: begin
        a         = rs1_data;
        b         = imm_i;
        reg_write = 1'b1;
        case (funct3)
          3'b000: operator = ALU_ADD;
          3'b001: begin
            operator = ALU_SLL;
            b        = shamt_i;
            bad      = (funct7 != F7_BASE);
          end
          3'b010: operator = ALU_SLT;
          3'b011: operator = ALU_SLTU;
          3'b100: operator = ALU_XOR;
          3'b101: begin
            b = shamt_i;
            if (funct7 == F7_BASE)     operator = ALU_SRL;
            else if (funct7 == F7_ALT) operator = ALU_SRA;
            else                       bad = 1'b1;
          end
          3'b110: operator = ALU_OR;
          default: operator = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        operator  = ALU_ADD;
        b         = imm_u;
        reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        operator  = ALU_ADD;
        a         = pc;
        b         = imm_u;
        reg_write = 1'b1;
      end
      OPC_LOAD: begin
        operator  = ALU_ADD;
        a         = rs1_data;
        b         = imm_i;
        reg_write = 1'b1;
      end
      OPC_STORE: begin
        operator = ALU_ADD;
        a        = rs1_data;
        b        = imm_s;
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      operator  = ALU_NONE;
      a         = '0;
      b         = '0;
      reg_write = 1'b0;
    end
    if (rd == 5'd0) reg_write = 1'b0;
    illegal = bad;
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Execute-stage issue register: decodes one RV32I instruction per transfer
// and holds it for the ALU behind a valid/ready output register.
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int OP_W    = 4
) (
  input logic             clk,
  input logic             rst,
  alu_op_encoder_if.slave bus
);

  logic [OP_W-1:0]    op_p0;
  logic [D_WIDTH-1:0] a_p0;
  logic [D_WIDTH-1:0] b_p0;
  logic [4:0]         rd_p0;
  logic               wr_p0;
  logic               ill_p0;

  ostate_t            state_p1;
  ostate_t            state_nxt;
  logic               vld_p1;
  logic [OP_W-1:0]    op_p1;
  logic [D_WIDTH-1:0] a_p1;
  logic [D_WIDTH-1:0] b_p1;
  logic [4:0]         rd_p1;
  logic               wr_p1;
  logic               ill_p1;

  logic in_xfer;
  logic out_xfer;
  logic load;

  alu_op_decode #(
    .D_WIDTH (D_WIDTH),
    .OP_W    (OP_W)
  ) u_decode (
    .instr     (bus.instr),
    .pc        (bus.pc),
    .rs1_data  (bus.rs1_data),
    .rs2_data  (bus.rs2_data),
    .operator  (op_p0),
    .a         (a_p0),
    .b         (b_p0),
    .rd        (rd_p0),
    .reg_write (wr_p0),
    .illegal   (ill_p0)
  );

  // ---- stage p0 -> p1: handshake and output register ----
  assign vld_p1       = (state_p1 == ST_FULL);
  assign bus.in_ready = !rst && (!vld_p1 || bus.out_ready);
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = vld_p1 && bus.out_ready;

  // Next state: flush beats load, load beats drain, otherwise hold.
  always_comb begin
    state_nxt = state_p1;
    load      = 1'b0;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else if (in_xfer) begin
      state_nxt = ST_FULL;
      load      = 1'b1;
    end else if (out_xfer) begin
      state_nxt = ST_EMPTY;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_p1 <= ST_EMPTY;
    else     state_p1 <= state_nxt;
  end

  // Decoded operation register; cleared on reset so the ALU sees a quiet bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_p1  <= '0;
      a_p1   <= '0;
      b_p1   <= '0;
      rd_p1  <= '0;
      wr_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (load) begin
      op_p1  <= op_p0;
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      rd_p1  <= rd_p0;
      wr_p1  <= wr_p0;
      ill_p1 <= ill_p0;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.operator  = op_p1;
  assign bus.a         = a_p1;
  assign bus.b         = b_p1;
  assign bus.rd        = rd_p1;
  assign bus.reg_write = wr_p1;
  assign bus.illegal   = ill_p1;

endmodule

// File: doc/alu_op_encoder.md
# alu_op_encoder

Execute-stage issue register that decodes a RISC-V RV32I instruction into the 4-bit operator code and the a/b operands consumed by the combinational ALU. It sits between the register-read stage and the ALU, holding one decoded operation in an output register with valid/ready handshakes on both sides. It also supports pipeline flush and flags unsupported encodings.

## Interface
- D_WIDTH, 32, datapath width; only 32 is supported.
- OP_W, 4, operator code width.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block accepts the upstream instruction this cycle.
- instr  in  32  instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  register-file read port 1.
- rs2_data  in  32  register-file read port 2.
- flush  in  1  discard the held operation.
- out_valid  out  1  decoded operation is present.
- out_ready  in  1  downstream consumes the operation.
- operator  out  OP_W  ALU operator code.
- a  out  32  ALU operand a.
- b  out  32  ALU operand b.
- rd  out  5  destination register index.
- reg_write  out  1  result is written back.
- illegal  out  1  instruction is not supported.

## Operation
- Operator codes: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and, 15 none (the ALU returns 0).
- OP (0110011):
  - a=rs1_data, b=rs2_data.
  - funct3/funct7 map as follows: 000/0000000 add, 000/0100000 sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101/0000000 srl, 101/0100000 sra, 110 or, 111 and.
  - Any other funct7 is illegal.
  - Shifts use b = {27'b0, rs2_data[4:0]}.
- OP-IMM (0010011):
  - a=rs1_data, b=sign-extended instr[31:20], same funct3 mapping.
  - There is no subi.
  - slli, srli and srai use b = {27'b0, instr[24:20]}.
  - srai requires instr[31:25]=0100000; slli and srli require 0000000. Otherwise the instruction is illegal.
- LUI (0110111): add, a=0, b={instr[31:12],12'b0}.
- AUIPC (0010111): add, a=pc, b=U-immediate.
- LOAD (0000011): add, a=rs1_data, b=I-immediate, reg_write=1.
- STORE (0100011): add, a=rs1_data, b=S-immediate {instr[31:25],instr[11:7]} sign-extended, reg_write=0.
- Writeback: reg_write=1 for OP, OP-IMM, LUI, AUIPC and LOAD. reg_write is forced to 0 when rd=0.
- Illegal instruction (any other opcode or a bad funct7):
  - illegal=1, operator=15, a=0, b=0, reg_write=0.
  - The operation is still emitted so the trap logic can see it.
- rd = instr[11:7] for every opcode.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- in_ready = !rst && (!out_valid || out_ready), combinational.
- A transfer occurs on a side when its valid and ready are both high at the clock edge.
- Accept and emit in the same cycle: the output register reloads with the new operation and out_valid stays 1. Full throughput is one operation per cycle.
- While out_valid=1 and out_ready=0, all outputs hold stable.
- flush=1:
  - out_valid clears at the next edge.
  - Any instruction offered in the same cycle is dropped.
  - in_ready remains as defined.
- Reset:
  - On the rst edge: out_valid=0, operator=0, a=0, b=0, rd=0, reg_write=0, illegal=0.
  - Reset in the middle of a stall discards the held operation.
- Priority at an edge: rst > flush > load > hold.
- The output register is a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on an input transfer.
  - FULL→EMPTY on an output transfer with no input transfer, or on flush.
  - FULL→FULL on hold, or on a simultaneous output and input transfer.

## Structure
- A shared package `alu_pkg` holds:
  - the operator code localparams (ALU_ADD … ALU_AND, ALU_NONE=15);
  - the opcode constants (OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_LOAD, OPC_STORE);
  - the funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
- The ALU consumes the same operator localparams.
- One combinational sub-module, `alu_op_decode`, maps instr/pc/rs1_data/rs2_data to the next operator, a, b, rd, reg_write and illegal.
- The top level holds only the handshake FSM and the output register.

## Test plan
- Reset, then instruction `add x3,x1,x2` (0x002081B3) with rs1=5, rs2=7 and out_ready=1. Required one cycle later: operator=0, a=5, b=7, rd=3, reg_write=1, out_valid=1.
- `srai x5,x6,4` (0x40435293) with rs1=0x80000000. Required: operator=7, b=4. The same encoding with instr[30]=0 gives operator=6. Instruction 0x20435293 gives illegal=1, operator=15.
- `sll` with rs2=0x00000025. Required: b=5. `sub` (funct7 0100000) gives operator=1. OP with funct7=0000001 gives illegal=1.
- `lui x1,0x12345` gives a=0, b=0x12345000. `auipc` at pc=0x100 gives a=0x100, b=0x12345000. `sw` with imm=-4 gives b=0xFFFFFFFC, reg_write=0. `addi x0,x0,1` gives reg_write=0.
- Handshake sequence:
  - out_ready=0 for 3 cycles while in_valid=1: outputs hold and in_ready=0.
  - Then out_ready=1: back-to-back stream of 4 instructions, one output per cycle, in order with no loss.
- Flush and reset:
  - flush=1 while FULL and in_valid=1: next cycle out_valid=0 and the offered instruction is not emitted.
  - rst=1 mid-stall: all outputs are 0 after the edge.
